// File: rtl/conv_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional encoder/decoder pair.
package conv_pkg;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  localparam int DEFAULT_FRAME_LEN = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/conv_enc_core.sv
// Combinational trellis step: (u, s) -> (next state, coded symbol {b1,b0}).
module conv_enc_core
  import conv_pkg::*;
(
  input  logic       u,
  input  logic [1:0] s,
  output logic [1:0] next_s,
  output logic [1:0] sym
);

  logic [2:0] win;

  // Window ordering {u, s[1], s[0]} lines up with the generator bit order.
  assign win    = {u, s};
  assign sym    = {^(win & G1), ^(win & G0)};
  assign next_s = {u, s[1]};

endmodule

// File: rtl/conv_enc_framer.sv
// Framed convolutional encoder: per-frame zeroed trellis, optional zero tail, one registered output stage.
//
// state | meaning
// IDLE  | after reset, waiting for enable
// DATA  | consuming input bits into the current frame
// TAIL  | appending zero-input termination symbols (TAIL_BITS=2 only)
module conv_enc_framer
  import conv_pkg::*;
#(
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int TAIL_BITS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] enc_out,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic       enc_sof,
  output logic       enc_eof
);

  localparam logic [7:0] LAST_SYM  = 8'(FRAME_LEN - 1);
  localparam logic [7:0] LAST_DATA = 8'(FRAME_LEN - TAIL_BITS - 1);

  fsm_state_t state;
  logic [7:0] cnt;
  logic [1:0] s;
  logic       out_free;
  logic       advance;
  logic       u;
  logic [1:0] next_s;
  logic [1:0] sym;

  assign out_free = !enc_valid || enc_ready;
  assign in_ready = enable && out_free && (state == DATA);
  assign advance  = enable && out_free &&
                    (((state == DATA) && in_valid) || (state == TAIL));
  assign u        = (state == DATA) ? in_bit : 1'b0;

  conv_enc_core u_core (
    .u      (u),
    .s      (s),
    .next_s (next_s),
    .sym    (sym)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_out   <= 2'b00;
      enc_valid <= 1'b0;
      enc_sof   <= 1'b0;
      enc_eof   <= 1'b0;
    end else if (advance) begin
      enc_out   <= sym;
      enc_valid <= 1'b1;
      enc_sof   <= (cnt == 8'd0);
      enc_eof   <= (cnt == LAST_SYM);
    end else if (enc_ready) begin
      enc_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      s     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= DATA;
            cnt   <= 8'd0;
            s     <= 2'b00;
          end
        end
        DATA: begin
          if (advance) begin
            if (cnt == LAST_DATA) begin
              if (TAIL_BITS == 0) begin
                cnt <= 8'd0;
                s   <= 2'b00;
              end else begin
                state <= TAIL;
                cnt   <= cnt + 8'd1;
                s     <= next_s;
              end
            end else begin
              cnt <= cnt + 8'd1;
              s   <= next_s;
            end
          end
        end
        TAIL: begin
          if (advance) begin
            // Every frame restarts the trellis at zero for the decoder.
            if (cnt == LAST_SYM) begin
              state <= DATA;
              cnt   <= 8'd0;
              s     <= 2'b00;
            end else begin
              cnt <= cnt + 8'd1;
              s   <= next_s;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_framer.sv
// Self-checking bench: two encoder instances (no tail / 2-bit tail) against a frame-level reference model.
module tb_conv_enc_framer;
  import conv_pkg::*;

  localparam int FL = 31;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic enc_ready = 1'b0;

  logic       r0_in_ready, r0_valid, r0_sof, r0_eof;
  logic [1:0] r0_out;
  logic       r1_in_ready, r1_valid, r1_sof, r1_eof;
  logic [1:0] r1_out;

  logic       sel = 1'b0;
  logic       s_ready, s_valid, s_sof, s_eof;
  logic [1:0] s_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected / observed symbols packed as {sof, eof, out[1:0]}
  logic [3:0] exp_q[$];
  logic [3:0] got[$];
  int   m_pos = 0;
  int   m_tail = 0;
  logic m_h1 = 1'b0;
  logic m_h2 = 1'b0;

  always #5 clk = ~clk;

  conv_enc_framer #(.FRAME_LEN(FL), .TAIL_BITS(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(r0_in_ready), .enc_out(r0_out), .enc_valid(r0_valid), .enc_ready(enc_ready),
    .enc_sof(r0_sof), .enc_eof(r0_eof)
  );

  conv_enc_framer #(.FRAME_LEN(FL), .TAIL_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(r1_in_ready), .enc_out(r1_out), .enc_valid(r1_valid), .enc_ready(enc_ready),
    .enc_sof(r1_sof), .enc_eof(r1_eof)
  );

  assign s_ready = sel ? r1_in_ready : r0_in_ready;
  assign s_valid = sel ? r1_valid    : r0_valid;
  assign s_sof   = sel ? r1_sof      : r0_sof;
  assign s_eof   = sel ? r1_eof      : r0_eof;
  assign s_out   = sel ? r1_out      : r0_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: convolution of the frame-local bit history with the generators.
  task automatic model_sym(input logic u);
    logic [2:0] win;
    logic [1:0] sym;
    if (m_pos == 0) begin
      m_h1 = 1'b0;
      m_h2 = 1'b0;
    end
    win = {u, m_h1, m_h2};
    sym = {^(win & G1), ^(win & G0)};
    exp_q.push_back({(m_pos == 0), (m_pos == FL - 1), sym});
    m_h2 = m_h1;
    m_h1 = u;
    m_pos = (m_pos + 1) % FL;
  endtask

  task automatic model_bit(input logic b);
    model_sym(b);
    if (m_tail == 2 && m_pos == FL - 2) begin
      model_sym(1'b0);
      model_sym(1'b0);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    got.delete();
    m_pos = 0;
  endtask

  // One clock: drive at negedge, sample #1 later; handshakes complete at the next posedge.
  task automatic cycle(input logic v, input logic b, input logic r, input logic e);
    @(negedge clk);
    in_valid = v;
    in_bit = b;
    enc_ready = r;
    enable = e;
    #1;
    if (s_valid && r) begin
      if (exp_q.size() == 0) begin
        check("unexpected_symbol", {28'd0, s_sof, s_eof, s_out}, 32'hFFFF_FFFF);
      end else begin
        check("symbol", {28'd0, s_sof, s_eof, s_out}, {28'd0, exp_q.pop_front()});
      end
      got.push_back({s_sof, s_eof, s_out});
    end
    if (v && s_ready) model_bit(b);
  endtask

  task automatic send_bit(input logic b, output int waits);
    waits = 0;
    forever begin
      cycle(1'b1, b, 1'b1, 1'b1);
      if (s_ready) break;
      waits++;
      if (waits > 50) begin
        check("send_timeout", 32'(waits), 32'd0);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      n++;
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_valid", {31'd0, s_valid}, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int w;
    logic [1:0] held_out;
    logic       held_valid;
    int         sofs;

    // Reset state
    #2;
    check("rst_out", {30'd0, s_out}, 32'd0);
    check("rst_valid0", {31'd0, s_valid}, 32'd0);
    check("rst_sof", {31'd0, s_sof}, 32'd0);
    check("rst_eof", {31'd0, s_eof}, 32'd0);
    check("rst_in_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Vector check
    sel = 1'b0; m_tail = 0;
    send_bit(1'b1, w); send_bit(1'b0, w); send_bit(1'b1, w); send_bit(1'b1, w);
    drain();
    check("vec0", {28'd0, got[0]}, {28'd0, 4'b1011});
    check("vec1", {30'd0, got[1][1:0]}, 32'd1);
    check("vec2", {30'd0, got[2][1:0]}, 32'd0);
    check("vec3", {30'd0, got[3][1:0]}, 32'd2);

    // Frame boundary with all ones
    do_reset();
    for (int i = 0; i < 62; i++) send_bit(1'b1, w);
    drain();
    check("ones_sym1", {30'd0, got[1][1:0]}, 32'd2);
    check("ones_sym2", {30'd0, got[2][1:0]}, 32'd1);
    check("ones_sym30", {28'd0, got[30]}, {28'd0, 4'b0101});
    check("ones_sym31", {28'd0, got[31]}, {28'd0, 4'b1011});

    // Backpressure mid-frame
    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), w);
    held_out = 2'b00;
    held_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      check("bp_in_ready", {31'd0, s_ready}, 32'd0);
      if (i == 0) begin
        held_out = s_out;
        held_valid = s_valid;
        check("bp_valid_start", {31'd0, s_valid}, 32'd1);
      end else begin
        check("bp_out_stable", {30'd0, s_out}, {30'd0, held_out});
        check("bp_valid_stable", {31'd0, s_valid}, {31'd0, held_valid});
      end
    end
    for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)), w);
    drain();

    // Enable low at counter 10
    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), w);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("en_in_ready", {31'd0, s_ready}, 32'd0);
      if (i > 0) check("en_no_symbol", {31'd0, s_valid}, 32'd0);
    end
    for (int i = 0; i < 25; i++) send_bit(1'($urandom_range(0, 1)), w);
    drain();
    sofs = 0;
    for (int i = 1; i < 31; i++) sofs += int'(got[i][3]);
    check("en_no_early_sof", 32'(sofs), 32'd0);
    check("en_sof_31", {31'd0, got[31][3]}, 32'd1);

    // Async reset at counter 15 with a symbol pending
    do_reset();
    for (int i = 0; i < 15; i++) send_bit(1'($urandom_range(0, 1)), w);
    @(posedge clk);
    #2;
    check("rst_pre_valid", {31'd0, s_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_async_valid", {31'd0, s_valid}, 32'd0);
    check("rst_async_sof", {31'd0, s_sof}, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    send_bit(1'b1, w);
    drain();
    check("rst_first", {28'd0, got[0]}, {28'd0, 4'b1011});

    // Tail termination
    sel = 1'b1; m_tail = 2;
    do_reset();
    for (int i = 0; i < 29; i++) send_bit(1'b1, w);
    send_bit(1'b1, w);
    check("tail_stall", 32'(w), 32'd2);
    drain();
    check("tail_sym0", {28'd0, got[29]}, {28'd0, 4'b0010});
    check("tail_sym1", {28'd0, got[30]}, {28'd0, 4'b0111});
    check("tail_next_sof", {28'd0, got[31]}, {28'd0, 4'b1011});

    // Randomized traffic on both variants
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0);
      m_tail = (k == 0) ? 2 : 0;
      do_reset();
      for (int i = 0; i < 700; i++)
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
